// File: rtl/cmp_arbiter.sv
// cmp_arbiter: shares one compare unit between two valid/ready requesters.
// Port 0 is the branch unit, port 1 the ALU set-less-than path. Round-robin on
// ties, one operation in flight, registered response tagged with id and tag.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   reqN_valid_i/ready_o  request handshake (ready is combinational)
//   reqN_a_i, reqN_b_i    32-bit operands
//   reqN_fn_i, reqN_tag_i compare function and pass-through tag
//   flush_i               abort any in-flight operation
//   resp_*                registered response (valid/ready, id, tag, result)
module cmp_arbiter #(
    parameter int unsigned TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid_i,
    output logic             req0_ready_o,
    input  logic [31:0]      req0_a_i,
    input  logic [31:0]      req0_b_i,
    input  logic [2:0]       req0_fn_i,
    input  logic [TAG_W-1:0] req0_tag_i,
    input  logic             req1_valid_i,
    output logic             req1_ready_o,
    input  logic [31:0]      req1_a_i,
    input  logic [31:0]      req1_b_i,
    input  logic [2:0]       req1_fn_i,
    input  logic [TAG_W-1:0] req1_tag_i,
    input  logic             flush_i,
    output logic             resp_valid_o,
    input  logic             resp_ready_i,
    output logic             resp_id_o,
    output logic [TAG_W-1:0] resp_tag_o,
    output logic [31:0]      resp_result_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               last_grant_q;
    logic [31:0]        op_a_q, op_b_q;
    logic [2:0]         op_fn_q;
    logic [TAG_W-1:0]   op_tag_q;
    logic               op_id_q;

    logic               grant_id;
    logic               accept;
    logic               resp_hs;
    logic [32:0]        diff;
    logic               flag_c, flag_z, flag_n, flag_v;
    logic               cmp_bit;

    // Arbitration: only in IDLE, never during flush or reset; ties go to the
    // requester that was not granted last.
    always_comb begin
        grant_id     = 1'b0;
        accept       = 1'b0;
        req0_ready_o = 1'b0;
        req1_ready_o = 1'b0;
        if (state_q == IDLE && !flush_i && !rst) begin
            if (req0_valid_i && req1_valid_i) begin
                grant_id = ~last_grant_q;
            end else begin
                grant_id = req1_valid_i;
            end
            accept       = req0_valid_i | req1_valid_i;
            req0_ready_o = accept & ~grant_id;
            req1_ready_o = accept & grant_id;
        end
    end

    assign resp_hs = resp_valid_o & resp_ready_i;

    // Next-state logic; flush wins over every transition.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (resp_hs) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush_i) begin
            state_d = IDLE;
        end
    end

    // Compare unit: flags from a - b computed as a + ~b + 1 (C = no borrow).
    always_comb begin
        diff    = {1'b0, op_a_q} + {1'b0, ~op_b_q} + 33'd1;
        flag_c  = diff[32];
        flag_z  = (diff[31:0] == 32'd0);
        flag_n  = diff[31];
        flag_v  = (op_a_q[31] ^ op_b_q[31]) & (diff[31] ^ op_a_q[31]);
        cmp_bit = 1'b0;
        case (op_fn_q)
            3'b000:  cmp_bit = flag_z;
            3'b001:  cmp_bit = ~flag_z;
            3'b010:  cmp_bit = ~(flag_n ^ flag_v);
            3'b011:  cmp_bit = flag_n;
            3'b100:  cmp_bit = flag_c & ~flag_z;
            3'b101:  cmp_bit = ~flag_c;
            3'b110:  cmp_bit = flag_c;
            default: cmp_bit = flag_v;
        endcase
    end

    // State, operand and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            last_grant_q  <= 1'b1;
            op_a_q        <= 32'd0;
            op_b_q        <= 32'd0;
            op_fn_q       <= 3'd0;
            op_tag_q      <= '0;
            op_id_q       <= 1'b0;
            resp_valid_o  <= 1'b0;
            resp_id_o     <= 1'b0;
            resp_tag_o    <= '0;
            resp_result_o <= 32'd0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_a_q       <= grant_id ? req1_a_i   : req0_a_i;
                op_b_q       <= grant_id ? req1_b_i   : req0_b_i;
                op_fn_q      <= grant_id ? req1_fn_i  : req0_fn_i;
                op_tag_q     <= grant_id ? req1_tag_i : req0_tag_i;
                op_id_q      <= grant_id;
                last_grant_q <= grant_id;
            end
            if (flush_i) begin
                resp_valid_o <= 1'b0;
            end else if (state_q == EXEC) begin
                resp_valid_o  <= 1'b1;
                resp_id_o     <= op_id_q;
                resp_tag_o    <= op_tag_q;
                resp_result_o <= {31'd0, cmp_bit};
            end else if (resp_hs) begin
                resp_valid_o <= 1'b0;
            end
        end
    end

endmodule
